// File: rtl/recip_sched_if.sv
// rtl/recip_sched_if.sv - request, response and engine signals of the reciprocal scheduler
interface recip_sched_if #(
  parameter int N_REQ   = 2,
  parameter int Q_WIDTH = 64
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*Q_WIDTH-1:0] req_d;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [Q_WIDTH-1:0]       rsp_data;
  logic                     rsp_err;

  logic                     rcp_start;
  logic [Q_WIDTH-1:0]       rcp_x;
  logic [Q_WIDTH-1:0]       rcp_d;
  logic [Q_WIDTH-1:0]       rcp_result;
  logic                     rcp_done;

  modport master (
    output req_valid, req_d, rsp_ready, rcp_result, rcp_done,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rcp_start, rcp_x, rcp_d
  );

  modport slave (
    input  req_valid, req_d, rsp_ready, rcp_result, rcp_done,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, rcp_start, rcp_x, rcp_d
  );
endinterface

// File: rtl/recip_sched.sv
// rtl/recip_sched.sv - round-robin scheduler sharing one Newton-Raphson reciprocal engine
// Range-checks D, seeds X0 = 48/17 - 32/17*D, runs the engine under a watchdog, returns id+result.
module recip_sched #(
  parameter int N_REQ   = 2,
  parameter int Q_INT   = 9,
  parameter int Q_FRAC  = 55,
  parameter int Q_WIDTH = Q_INT + Q_FRAC,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  recip_sched_if.slave bus
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int CW    = Q_WIDTH + 7;

  // Seed constants rounded to nearest: (k * 2^Q_FRAC + 17/2) / 17
  localparam logic [CW-1:0] SCALE = CW'(1) << Q_FRAC;
  localparam logic [CW-1:0] C1_W  = (SCALE * CW'(48) + CW'(8)) / CW'(17);
  localparam logic [CW-1:0] C2_W  = (SCALE * CW'(32) + CW'(8)) / CW'(17);
  localparam logic [Q_WIDTH-1:0] C1 = C1_W[Q_WIDTH-1:0];
  localparam logic [Q_WIDTH-1:0] C2 = C2_W[Q_WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state;
  logic [ID_W-1:0]      ptr;
  logic [CNT_W-1:0]     cnt;

  logic                 grant_any;
  logic [ID_W-1:0]      grant_idx;
  logic [Q_WIDTH-1:0]   d_sel;
  logic                 d_ok;
  logic [2*Q_WIDTH-1:0] prod;
  logic [Q_WIDTH-1:0]   seed;

  // First valid requester at or after the pointer, wrapping
  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!grant_any && bus.req_valid[j]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(j);
      end
    end
  end

  assign bus.req_ready = (state == IDLE && grant_any && !reset) ? (N_REQ'(1) << grant_idx) : '0;

  assign d_sel = bus.req_d[int'(grant_idx) * Q_WIDTH +: Q_WIDTH];
  assign d_ok  = (d_sel[Q_WIDTH-1:Q_FRAC] == '0) && d_sel[Q_FRAC-1];
  assign prod  = {{Q_WIDTH{1'b0}}, d_sel} * {{Q_WIDTH{1'b0}}, C2};
  assign seed  = C1 - Q_WIDTH'(prod >> Q_FRAC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      cnt           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rcp_start <= 1'b0;
      bus.rcp_x     <= '0;
      bus.rcp_d     <= '0;
    end else begin
      bus.rcp_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            ptr        <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
            bus.rsp_id <= grant_idx;
            bus.rcp_d  <= d_sel;
            bus.rcp_x  <= seed;
            if (d_ok) begin
              bus.rcp_start <= 1'b1;
              state         <= ISSUE;
            end else begin
              bus.rsp_err   <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_valid <= 1'b1;
              state         <= RESP;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A done arriving on the last allowed cycle still counts as success
          if (bus.rcp_done) begin
            bus.rsp_data  <= bus.rcp_result;
            bus.rsp_err   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_recip_sched.sv
// tb/tb_recip_sched.sv - randomized self-checking bench for recip_sched
// Engine model with programmable done delay; expected values from arithmetic reference model.
module tb_recip_sched;
  localparam int N  = 2;
  localparam int QW = 64;
  localparam int QF = 55;
  localparam int TO = 16;
  localparam logic [63:0] K_C1 = 64'd101728368053545321;
  localparam logic [63:0] K_C2 = 64'd67818912035696881;

  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  recip_sched_if #(.N_REQ(N), .Q_WIDTH(QW)) bus ();

  recip_sched #(.N_REQ(N), .Q_INT(9), .Q_FRAC(QF), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          ptr_m   = 0;
  logic [63:0] d_in [N];
  logic [63:0] last_x;

  int          eng_delay = 0;
  logic [63:0] eng_result = '0;
  int          eng_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Engine: done pulse eng_delay cycles after start; delay 0 never finishes
  always @(negedge clk) begin
    logic d;
    d = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) d = 1'b1;
    end
    if (bus.rcp_start === 1'b1 && eng_delay > 0) eng_cnt = eng_delay;
    bus.rcp_done   = d;
    bus.rcp_result = d ? eng_result : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  function automatic int pick(input int p, input logic [N-1:0] m);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [63:0] model_seed(input logic [63:0] d);
    logic [127:0] p;
    p = {64'd0, d} * {64'd0, K_C2};
    return K_C1 - p[118:55];
  endfunction

  task automatic drive_d();
    for (int i = 0; i < N; i++) bus.req_d[i*QW +: QW] = d_in[i];
  endtask

  task automatic transact(input logic [N-1:0] mask, input bit keep, input int delay,
                          input int lag, input logic [63:0] result);
    int g, k, k_rsp, k_start, n_start, exp_lat;
    bit ok, err, stable, busy_rdy, hs, fin;
    logic [63:0] dg, x_seen, d_seen, h_id, h_data, h_err;
    logic [N-1:0] onehot;
    eng_delay  = delay;
    eng_result = result;
    drive_d();
    bus.req_valid = mask;
    #1;
    g = pick(ptr_m, mask);
    onehot = '0;
    onehot[g] = 1'b1;
    check("grant", bus.req_ready, onehot);
    dg = d_in[g];
    ok = (dg[63:55] == 9'd0) && dg[54];
    ptr_m = (g + 1) % N;
    @(negedge clk);
    if (!keep) bus.req_valid = '0;
    k = 1; k_rsp = -1; k_start = -1; n_start = 0;
    stable = 1; busy_rdy = 0; hs = 0; fin = 0;
    x_seen = '0; d_seen = '0; h_id = '0; h_data = '0; h_err = '0;
    while (!fin && k < 60) begin
      #1;
      bus.rsp_ready = 1'b0;
      if (bus.rcp_start) begin
        n_start++; k_start = k; x_seen = bus.rcp_x; d_seen = bus.rcp_d;
      end
      if (hs) begin
        check("rsp_drop", bus.rsp_valid, 0);
        fin = 1;
      end else begin
        if (bus.req_ready !== '0) busy_rdy = 1;
        if (bus.rsp_valid) begin
          if (k_rsp < 0) begin
            k_rsp = k; h_id = bus.rsp_id; h_data = bus.rsp_data; h_err = bus.rsp_err;
          end else if (bus.rsp_id !== h_id || bus.rsp_data !== h_data || bus.rsp_err !== h_err) begin
            stable = 0;
          end
          if (k >= k_rsp + lag) begin
            bus.rsp_ready = 1'b1;
            hs = 1;
          end
        end
        @(negedge clk);
        k++;
      end
    end
    bus.rsp_ready = 1'b0;
    last_x = x_seen;
    err = !ok || delay < 1 || delay > TO;
    exp_lat = !ok ? 1 : (err ? TO + 2 : delay + 2);
    check("rsp_seen", fin, 1);
    check("no_ready_busy", busy_rdy, 0);
    check("start_count", n_start, ok ? 1 : 0);
    if (ok) begin
      check("start_cycle", k_start, 1);
      check("rcp_x", x_seen, model_seed(dg));
      check("rcp_d", d_seen, dg);
    end
    check("rsp_latency", k_rsp, exp_lat);
    check("rsp_id", h_id, g);
    check("rsp_err", h_err, err);
    check("rsp_data", h_data, err ? 64'd0 : result);
    check("rsp_stable", stable, 1);
  endtask

  task automatic idle_check(input int n);
    bit bad;
    bad = 0;
    bus.req_valid = '0;
    repeat (n) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid !== 1'b0 || bus.rcp_start !== 1'b0 || bus.req_ready !== '0) bad = 1;
    end
    check("idle_quiet", bad, 0);
  endtask

  function automatic logic [63:0] rand_d();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0, 1:    return {9'd0, 1'b1, r[53:0]};
      2:       return r;
      default: return {9'd0, 1'b0, r[53:0]};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_d     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) d_in[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rcp_start", bus.rcp_start, 0);
    check("rst_rcp_x", bus.rcp_x, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_req_ready", bus.req_ready, 0);
    reset = 1'b0;
    @(negedge clk);

    // D = 0.5 from requester 1; seed equals 32/17
    d_in[0] = 64'h0060_0000_0000_0000;
    d_in[1] = 64'h0040_0000_0000_0000;
    transact(2'b10, 0, 5, 0, 64'h0100_0000_0000_0000);
    check("x0_half", last_x, K_C2);

    // Fairness with both requesters held valid
    for (int i = 0; i < 8; i++) begin
      d_in[0] = {9'd0, 1'b1, 22'd0, $urandom};
      d_in[1] = {9'd0, 1'b1, $urandom, 22'd0};
      transact(2'b11, 1, 5, 0, {$urandom, $urandom});
    end
    bus.req_valid = '0;

    // Out-of-range divisors: 1.0 and 0.25, plus both range edges
    d_in[0] = 64'h0080_0000_0000_0000;
    transact(2'b01, 0, 5, 0, 64'h1234);
    d_in[1] = 64'h0020_0000_0000_0000;
    transact(2'b10, 0, 5, 0, 64'h1234);
    d_in[0] = 64'h007F_FFFF_FFFF_FFFF;
    transact(2'b01, 0, 5, 0, 64'h0080_0000_0000_0001);
    d_in[1] = 64'h003F_FFFF_FFFF_FFFF;
    transact(2'b10, 0, 5, 0, 64'h1234);

    // Watchdog: never done, late done, done on the last allowed cycle, one cycle too late
    d_in[0] = 64'h0050_0000_0000_0000;
    d_in[1] = 64'h0070_0000_0000_0000;
    transact(2'b01, 0, 0, 0, 64'h5555);
    idle_check(4);
    transact(2'b10, 0, 20, 0, 64'h6666);
    idle_check(6);
    transact(2'b01, 0, TO, 0, 64'h7777);
    transact(2'b10, 0, TO + 1, 0, 64'h8888);
    idle_check(6);

    // Response stall with both requesters pending
    transact(2'b11, 1, 3, 10, 64'h0123_4567_89AB_CDEF);
    bus.req_valid = '0;
    idle_check(2);

    // Reset while waiting on the engine
    d_in[0] = 64'h0050_0000_0000_0000;
    drive_d();
    eng_delay = 0;
    bus.req_valid = 2'b01;
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 2'b11;
    @(negedge clk);
    #1;
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_rsp_id", bus.rsp_id, 0);
    check("mid_rst_rsp_err", bus.rsp_err, 0);
    check("mid_rst_rcp_x", bus.rcp_x, 0);
    check("mid_rst_rcp_d", bus.rcp_d, 0);
    check("mid_rst_req_ready", bus.req_ready, 0);
    reset = 1'b0;
    bus.req_valid = '0;
    ptr_m = 0;
    @(negedge clk);
    transact(2'b11, 0, 5, 0, 64'h0100_0000_0000_0000);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      int dly;
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int r = 0; r < N; r++) d_in[r] = rand_d();
      dly = $urandom_range(0, 20);
      transact(m, 0, dly, $urandom_range(0, 3), {$urandom, $urandom});
      if (dly == 0 || dly > TO) idle_check(6);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/recip_sched.md
Name: recip_sched

Overview:
Round-robin scheduler that shares one Newton-Raphson reciprocal engine between N_REQ requesters, such as the divide and sqrt front ends. It range-checks each divisor and computes the linear seed X0 = 48/17 - (32/17)*D. It issues the start pulse to the engine, waits for done under a watchdog, then returns the result with the requester id over a valid/ready response port.

Parameters:
N_REQ, 2, number of requesters (>=2)
Q_INT, 9, integer bits of the fixed-point format (incl. sign)
Q_FRAC, 55, fractional bits
Q_WIDTH, Q_INT+Q_FRAC, operand width
TIMEOUT, 16, max cycles from rcp_start to rcp_done before error

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_d  in  N_REQ*Q_WIDTH  packed divisors, requester i at [i*Q_WIDTH +: Q_WIDTH]
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accept
rsp_id  out  $clog2(N_REQ)  requester index of the response
rsp_data  out  Q_WIDTH  reciprocal in Q_INT.Q_FRAC
rsp_err  out  1  1 = divisor out of range or engine timeout; rsp_data = 0
rcp_start  out  1  one-cycle start pulse to the engine
rcp_x  out  Q_WIDTH  seed to the engine
rcp_d  out  Q_WIDTH  divisor to the engine
rcp_result  in  Q_WIDTH  engine result
rcp_done  in  1  engine one-cycle done pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = 0; timeout counter = 0.
- Reset also covers a mid-operation reset: the pending request is dropped with no response. Top level drives the engine reset as ~reset so both sides idle together.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready is combinational, one-hot on the first valid requester at or after the pointer (wrapping). It is 0 in every other state.
- Accept cycle: latch id and D; pointer <= id+1 mod N_REQ.
- Range check at accept: valid iff bits [Q_WIDTH-1:Q_FRAC] == 0 and bit Q_FRAC-1 == 1, i.e. D in [0.5,1).
  - Valid -> ISSUE.
  - Invalid -> RESP with rsp_err=1, rsp_data=0; the engine is not started.
- Seed computation:
  - X0 = C1 - ((D*C2) >> Q_FRAC), using a full 2*Q_WIDTH product.
  - C1 = round(48/17 * 2^Q_FRAC); C2 = round(32/17 * 2^Q_FRAC).
  - Computed combinationally from latched D and registered into rcp_x in the accept cycle.
- ISSUE: rcp_start=1 for exactly one cycle with rcp_x and rcp_d stable; next state WAIT; timeout counter cleared.
  - rcp_x/rcp_d hold their values until the next accept.
- WAIT: counter increments each cycle.
  - rcp_done=1 -> latch rcp_result into rsp_data, rsp_err=0, go to RESP.
  - Counter reaches TIMEOUT with no done -> rsp_err=1, rsp_data=0, go to RESP.
  - If rcp_done and the timeout occur in the same cycle, done wins.
- RESP: rsp_valid=1 with rsp_id/rsp_data/rsp_err stable until rsp_ready=1.
  - The handshake cycle returns to IDLE with rsp_valid=0 next cycle.
  - No new request is accepted in the handshake cycle.
- rcp_done outside WAIT is ignored; a late done after a timeout is discarded.
- Latency with a 4-iteration engine (done 5 cycles after start), rsp_ready held high:
  - Accept at T, rcp_start at T+1, rcp_done at T+6, rsp_valid at T+7.
  - Out-of-range: rsp_valid at T+1.
- Throughput: one request in flight; back-to-back minimum 8 cycles.
- Fairness: with all requesters valid continuously, grants rotate 0,1,...,N_REQ-1,0.

Test Plan:
- Single request, D=0x0040000000000000 (0.5) from req 1: rcp_start one cycle at T+1, rcp_x=round(32/17*2^55); engine model returns 0x0100000000000000 -> rsp_valid at T+7, rsp_id=1, rsp_err=0.
- All N_REQ=2 valid continuously, 4 requests each: grant order 0,1,0,1,...; req_ready never high outside IDLE.
- D=0x0080000000000000 (1.0) and D=0x0020000000000000 (0.25): rsp_err=1, rsp_data=0, no rcp_start pulse, rsp_valid at T+1.
- Engine model never asserts done: rsp_err=1 after TIMEOUT=16 WAIT cycles; a done pulse injected afterwards is ignored.
- rsp_ready low for 10 cycles in RESP: outputs stable, no new req_ready. Raising rsp_ready gives a one-cycle handshake, then IDLE.
- Assert reset during WAIT: next cycle all outputs 0 and pointer 0. After release, a request from req 0 is served normally and no stale response appears.
